// File: rtl/sram_controller_if.sv
// rtl/sram_controller_if.sv - MEM-stage request/response bundle for the SRAM controller
interface sram_controller_if;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;

    modport master (
        output wr_en, rd_en, address, write_data,
        input  read_data, ready
    );

    modport slave (
        input  wr_en, rd_en, address, write_data,
        output read_data, ready
    );
endinterface

// File: rtl/sram_controller.sv
// rtl/sram_controller.sv - 32-bit word access to a 16-bit async SRAM as two half-word phases
module sram_controller #(
    parameter int ADDR_BASE   = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    sram_controller_if.slave   mem,
    inout  wire  [15:0]        SRAM_DQ,
    output logic [17:0]        SRAM_ADDR,
    output logic               SRAM_WE_N,
    output logic               SRAM_UB_N,
    output logic               SRAM_LB_N,
    output logic               SRAM_CE_N,
    output logic               SRAM_OE_N
);

    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOW,
        HIGH,
        DONE
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             is_wr_q;
    logic [16:0]      word_q;
    logic             half_q;
    logic [31:0]      rdata_q;
    logic             we_n_q;
    logic             oe_n_q;
    logic             dq_oe_q;
    logic [15:0]      dq_out_q;

    logic             req;
    logic [16:0]      word_live;

    assign req       = mem.rd_en | mem.wr_en;
    assign word_live = 17'((mem.address - 32'(ADDR_BASE)) >> 2);

    // The word is captured at the start of an access so a dropped request cannot move it mid-flight.
    assign SRAM_ADDR = (state_q == IDLE) ? {word_live, 1'b0} : {word_q, half_q};
    assign SRAM_DQ   = dq_oe_q ? dq_out_q : 16'bz;
    assign SRAM_WE_N = we_n_q;
    assign SRAM_OE_N = oe_n_q;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign SRAM_CE_N = 1'b0;

    assign mem.read_data = rdata_q;
    assign mem.ready     = ~req | (state_q == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            is_wr_q  <= 1'b0;
            word_q   <= '0;
            half_q   <= 1'b0;
            rdata_q  <= '0;
            we_n_q   <= 1'b1;
            oe_n_q   <= 1'b0;
            dq_oe_q  <= 1'b0;
            dq_out_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req) begin
                        state_q  <= LOW;
                        cnt_q    <= '0;
                        is_wr_q  <= mem.wr_en;
                        word_q   <= word_live;
                        half_q   <= 1'b0;
                        we_n_q   <= ~mem.wr_en;
                        oe_n_q   <= mem.wr_en;
                        dq_oe_q  <= mem.wr_en;
                        dq_out_q <= mem.write_data[15:0];
                    end
                end
                LOW: begin
                    if (cnt_q == CNT_LAST) begin
                        state_q  <= HIGH;
                        cnt_q    <= '0;
                        half_q   <= 1'b1;
                        dq_out_q <= mem.write_data[31:16];
                        if (!is_wr_q) begin
                            rdata_q[15:0] <= SRAM_DQ;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                HIGH: begin
                    if (cnt_q == CNT_LAST) begin
                        state_q <= DONE;
                        cnt_q   <= '0;
                        half_q  <= 1'b0;
                        we_n_q  <= 1'b1;
                        oe_n_q  <= 1'b0;
                        dq_oe_q <= 1'b0;
                        if (!is_wr_q) begin
                            rdata_q[31:16] <= SRAM_DQ;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_controller.sv
// tb/tb_sram_controller.sv - directed vector bench for sram_controller with a behavioural SRAM
module tb_sram_controller;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sram_controller_if mem_if ();

    wire  [15:0] sram_dq;
    logic [17:0] sram_addr;
    logic        we_n, ub_n, lb_n, ce_n, oe_n;

    sram_controller #(
        .ADDR_BASE  (1024),
        .WAIT_CYCLES(2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .mem      (mem_if.slave),
        .SRAM_DQ  (sram_dq),
        .SRAM_ADDR(sram_addr),
        .SRAM_WE_N(we_n),
        .SRAM_UB_N(ub_n),
        .SRAM_LB_N(lb_n),
        .SRAM_CE_N(ce_n),
        .SRAM_OE_N(oe_n)
    );

    logic [15:0] sram_mem [0:262143];

    assign sram_dq = (!oe_n && we_n) ? sram_mem[sram_addr] : 16'bz;

    always @(posedge clk) begin
        if (!we_n) sram_mem[sram_addr] <= sram_dq;
    end

    typedef struct {
        logic        wr;
        logic        rd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [0:7];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [16:0] word_of(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - 32'd1024;
        return off[18:2];
    endfunction

    task automatic run_access(input int i);
        vec_t        v;
        logic [16:0] w;
        logic        half;
        logic        phase;
        logic [17:0] ea;
        v = vecs[i];
        w = word_of(v.addr);
        @(posedge clk);
        #1;
        mem_if.wr_en      = v.wr;
        mem_if.rd_en      = v.rd;
        mem_if.address    = v.addr;
        mem_if.write_data = v.wdata;
        for (int c = 0; c <= 5; c++) begin
            @(negedge clk);
            phase = (c >= 1 && c <= 4);
            half  = (c == 3 || c == 4);
            ea    = {w, half};
            check($sformatf("v%0d c%0d ready", i, c), {31'd0, mem_if.ready}, {31'd0, c == 5});
            check($sformatf("v%0d c%0d we_n", i, c), {31'd0, we_n}, {31'd0, phase ? ~v.wr : 1'b1});
            check($sformatf("v%0d c%0d oe_n", i, c), {31'd0, oe_n}, {31'd0, phase ? v.wr : 1'b0});
            check($sformatf("v%0d c%0d addr", i, c), {14'd0, sram_addr}, {14'd0, ea});
            if (phase && v.wr) begin
                check($sformatf("v%0d c%0d dq", i, c), {16'd0, sram_dq},
                      {16'd0, half ? v.wdata[31:16] : v.wdata[15:0]});
            end else begin
                check($sformatf("v%0d c%0d dq_released", i, c), {16'd0, sram_dq}, {16'd0, sram_mem[ea]});
            end
            if (c == 5) begin
                check($sformatf("v%0d rdata", i), mem_if.read_data, v.exp_rdata);
            end
        end
    endtask

    task automatic idle_cycles(input int n, input logic [31:0] exp_rd);
        @(posedge clk);
        #1;
        mem_if.wr_en = 1'b0;
        mem_if.rd_en = 1'b0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            check($sformatf("idle%0d ready", k), {31'd0, mem_if.ready}, 32'd1);
            check($sformatf("idle%0d we_n", k), {31'd0, we_n}, 32'd1);
            check($sformatf("idle%0d oe_n", k), {31'd0, oe_n}, 32'd0);
            check($sformatf("idle%0d dq_released", k), {16'd0, sram_dq}, {16'd0, sram_mem[sram_addr]});
            check($sformatf("idle%0d rdata", k), mem_if.read_data, exp_rd);
        end
    endtask

    initial begin
        for (int a = 0; a < 262144; a++) sram_mem[a] = 16'h0000;
        vecs[0] = '{1'b1, 1'b0, 32'd1028, 32'hDEADBEEF, 32'h00000000};
        vecs[1] = '{1'b0, 1'b1, 32'd1028, 32'h00000000, 32'hDEADBEEF};
        vecs[2] = '{1'b1, 1'b1, 32'd1032, 32'h12345678, 32'hDEADBEEF};
        vecs[3] = '{1'b0, 1'b1, 32'd1032, 32'h00000000, 32'h12345678};
        vecs[4] = '{1'b1, 1'b0, 32'd1024, 32'h0BADC0DE, 32'h00000000};
        vecs[5] = '{1'b1, 1'b0, 32'd1036, 32'h55AA33CC, 32'h00000000};
        vecs[6] = '{1'b0, 1'b1, 32'd1039, 32'h00000000, 32'h55AA33CC};
        vecs[7] = '{1'b0, 1'b1, 32'd1024, 32'h00000000, 32'h0BADC0DE};

        rst               = 1'b1;
        mem_if.wr_en      = 1'b0;
        mem_if.rd_en      = 1'b0;
        mem_if.address    = 32'd1024;
        mem_if.write_data = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        idle_cycles(10, 32'h0);
        run_access(0);
        check("mem2 after write", {16'd0, sram_mem[2]}, 32'h0000BEEF);
        check("mem3 after write", {16'd0, sram_mem[3]}, 32'h0000DEAD);
        run_access(1);
        idle_cycles(3, 32'hDEADBEEF);
        run_access(2);
        run_access(3);

        // Reset lands in the second LOW cycle: only the low half reaches the array.
        @(posedge clk);
        #1;
        mem_if.wr_en      = 1'b1;
        mem_if.rd_en      = 1'b0;
        mem_if.address    = 32'd1040;
        mem_if.write_data = 32'hCAFEF00D;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst we_n", {31'd0, we_n}, 32'd1);
        check("rst oe_n", {31'd0, oe_n}, 32'd0);
        check("rst rdata", mem_if.read_data, 32'h0);
        check("rst addr", {14'd0, sram_addr}, 32'd8);
        check("rst ready", {31'd0, mem_if.ready}, 32'd0);
        check("rst dq_released", {16'd0, sram_dq}, {16'd0, sram_mem[8]});
        @(posedge clk);
        #1;
        rst = 1'b0;
        mem_if.wr_en = 1'b0;
        idle_cycles(2, 32'h0);
        check("rst mem8 low half", {16'd0, sram_mem[8]}, 32'h0000F00D);
        check("rst mem9 untouched", {16'd0, sram_mem[9]}, 32'h00000000);

        for (int i = 4; i <= 7; i++) run_access(i);
        idle_cycles(2, 32'h0BADC0DE);
        check("mem6", {16'd0, sram_mem[6]}, 32'h000033CC);
        check("mem7", {16'd0, sram_mem[7]}, 32'h000055AA);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
